ienc32: RTL and testbench
=========================

# ienc32

Pipelined RV32IM instruction encoder: the inverse of the instruction decode unit. It accepts an instruction index (same 0..45 numbering the decoder emits) plus register and immediate operands over a valid/ready handshake, and produces the 32-bit instruction word with a word address. Used by the boot/program loader and by the self-test generator to write instruction memory.

## Interface
- `NR_INST`, 46: number of encodable indices (0..45).
- `IDX_W`, 6: index width.
- `ADDR_W`, 10: word-address counter width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid & in_ready`.
- `in_idx` in IDX_W: instruction index.
  - 0–9: add, sub, xor, or, and, sll, srl, sra, slt, sltu.
  - 10–18: addi, xori, ori, andi, slli, srli, srai, slti, sltiu.
  - 19–23: lb, lh, lw, lbu, lhu. 24–26: sb, sh, sw.
  - 27–32: beq, bne, blt, bge, bltu, bgeu.
  - 33: jal. 34: jalr. 35: lui. 36: auipc. 37: ecall/ebreak.
  - 38–45: mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
- `in_rd`, `in_rs1`, `in_rs2` in 5 each: register numbers; ignored where the format has no such field.
- `in_imm` in 32: signed byte offset/immediate. U-type takes the full value; bits [31:12] are used.
- `addr_clr` in 1: synchronous clear of the address counter.
- `out_valid` out 1: word valid.
- `out_ready` in 1: consumer accepts on `out_valid & out_ready`.
- `out_inst` out 32: encoded instruction.
- `out_addr` out ADDR_W: word address of `out_inst`.
- `out_err` out 1: word flagged illegal/out of range; qualified by `out_valid`.

## Operation
- Stage 1 (S1) registers the request and decodes the format: R, I, I-shift, load, S, B, J, jalr, U, ENV.
- Stage 2 (S2) registers the assembled word and the error flag.
- Field placement follows the RV32 base formats:
  - B takes imm[12:1]; J takes imm[20:1].
  - For shifts, funct7 is 0x00, or 0x20 for srai; the shamt is imm[4:0].
  - M ops use funct7 0x01.
- ENV (idx 37): rd, rs1 and funct3 are forced to 0; `in_imm[0]` selects ecall (0, giving 0x00000073) or ebreak (1, giving 0x00100073).
- `in_idx` ≥ NR_INST: `out_inst` = 0x00000000 and `out_err` = 1, in both configurations.
- Address counter:
  - `out_addr` = counter value.
  - Counter increments on each output handshake, including errored words.
  - Wraps from 2^ADDR_W−1 to 0.
- `addr_clr` together with an output handshake: the transferred word keeps its address, and the counter becomes 0 (clear wins).
- Order is strictly preserved; nothing is dropped or duplicated.

## Timing
- Latency: 2 cycles from accept to `out_valid`, with `out_ready` held at 1.
- Throughput: 1 word per cycle.
- `in_ready` = `!s1_v | !s2_v | out_ready`. This is a combinational path from `out_ready`, permitted by design.
- Stall (`out_valid & !out_ready`): `out_inst`, `out_addr` and `out_err` hold stable. At most 2 requests are buffered; then `in_ready` = 0.
- Reset values: `out_valid` = 0, `out_inst` = 0, `out_err` = 0, `out_addr` = 0, both stage valids = 0, and hence `in_ready` = 1.
- Reset asserted mid-operation discards in-flight words immediately.

## Configuration
- `IENC32_RANGE_CHECK_EN` defined: `out_err` is also set when the immediate does not fit its format:
  - I/load/S/jalr: outside [−2048, 2047].
  - B: outside [−4096, 4094], or imm[0] ≠ 0.
  - J: outside [−2^20, 2^20−2], or imm[0] ≠ 0.
  - Shift: imm[31:5] ≠ 0.
  - U: imm[11:0] ≠ 0.
  - ENV: imm ∉ {0, 1}.
  - The word is still emitted with a truncated immediate.
- Undefined: immediates are silently truncated; `out_err` flags only an illegal index.

## Structure
- Package `ienc32_pkg` holds:
  - opcode constants (0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37, 0x17, 0x73);
  - index constants `IDX_ADD` .. `IDX_REMU`;
  - the format enum;
  - an index→{opcode, funct3, funct7, format} lookup function.
- Sub-module `ienc32_fmt`: combinational field assembly plus range check, instantiated between S1 and S2.
- The top level holds the handshake, the two stages and the address counter.

## Test plan
- add (idx 0), rd=1, rs1=2, rs2=3 → `out_inst` 0x003100B3, `out_addr` 0, `out_valid` 2 cycles after accept.
- Back-to-back, one per cycle, four words → 0x407302B3 (sub, idx 1, rd=5/rs1=6/rs2=7), 0xFFF00093 (addi, idx 10, rd=1, imm=−1), 0xFE208EE3 (beq, idx 27, rs1=1, rs2=2, imm=−4), 0x123450B7 (lui, idx 35, rd=1, imm=0x12345000); addresses 0–3.
- ENV: idx 37, imm=0 → 0x00000073; imm=1 → 0x00100073.
- Errors:
  - idx 50 → 0x00000000 with `out_err` = 1.
  - addi, rd=1, imm=2048 → 0x80000093; `out_err` = 1 with `IENC32_RANGE_CHECK_EN`, 0 without.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles while driving 4 requests → `in_ready` drops after 2 accepts and outputs stay stable.
  - Release → all 4 words delivered in order.
- ADDR_W=2, 5 words → addresses 0,1,2,3,0.
- `addr_clr` on the handshake of the word at address 2 → next word has address 0.
- `rst` asserted mid-stream → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/ienc32_pkg.sv
// Shared types and constants for the RV32IM instruction encoder.
// Index numbering matches the decoder's 0..45 instruction index.
package ienc32_pkg;

    localparam int IDX_W   = 6;
    localparam int NR_INST = 46;
    localparam logic [IDX_W-1:0] NR_INST_IDX = IDX_W'(NR_INST);

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LD    = 7'h03;
    localparam logic [6:0] OP_S     = 7'h23;
    localparam logic [6:0] OP_B     = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_SYS   = 7'h73;

    localparam int IDX_ADD  = 0,  IDX_SUB  = 1,  IDX_XOR   = 2,  IDX_OR    = 3,  IDX_AND  = 4;
    localparam int IDX_SLL  = 5,  IDX_SRL  = 6,  IDX_SRA   = 7,  IDX_SLT   = 8,  IDX_SLTU = 9;
    localparam int IDX_ADDI = 10, IDX_XORI = 11, IDX_ORI   = 12, IDX_ANDI  = 13, IDX_SLLI = 14;
    localparam int IDX_SRLI = 15, IDX_SRAI = 16, IDX_SLTI  = 17, IDX_SLTIU = 18;
    localparam int IDX_LB   = 19, IDX_LH   = 20, IDX_LW    = 21, IDX_LBU   = 22, IDX_LHU  = 23;
    localparam int IDX_SB   = 24, IDX_SH   = 25, IDX_SW    = 26;
    localparam int IDX_BEQ  = 27, IDX_BNE  = 28, IDX_BLT   = 29, IDX_BGE   = 30, IDX_BLTU = 31;
    localparam int IDX_BGEU = 32, IDX_JAL  = 33, IDX_JALR  = 34, IDX_LUI   = 35, IDX_AUIPC = 36;
    localparam int IDX_ENV  = 37, IDX_MUL  = 38, IDX_MULH  = 39, IDX_MULHSU = 40, IDX_MULHU = 41;
    localparam int IDX_DIV  = 42, IDX_DIVU = 43, IDX_REM   = 44, IDX_REMU  = 45;

    typedef enum logic [3:0] {
        FMT_R, FMT_I, FMT_ISH, FMT_LD, FMT_S, FMT_B, FMT_J, FMT_JALR, FMT_U, FMT_ENV
    } fmt_e;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        fmt_e       fmt;
    } dec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    // funct3 for the ALU ops in R-group order (add sub xor or and sll srl sra slt sltu)
    function automatic logic [2:0] alu_f3(input int k);
        case (k)
            2:       return 3'd4;
            3:       return 3'd6;
            4:       return 3'd7;
            5:       return 3'd1;
            6, 7:    return 3'd5;
            8:       return 3'd2;
            9:       return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    // Out-of-range indices land in the M branch; the caller flags them separately.
    function automatic dec_t idx_lookup(input logic [IDX_W-1:0] idx);
        dec_t d;
        int   i;
        i     = int'(idx);
        d.op  = OP_R;
        d.f3  = 3'd0;
        d.f7  = 7'h00;
        d.fmt = FMT_R;
        if (i <= IDX_SLTU) begin
            d.f3 = alu_f3(i);
            if (i == IDX_SUB || i == IDX_SRA) d.f7 = 7'h20;
        end else if (i <= IDX_SLTIU) begin
            d.op  = OP_I;
            d.f3  = alu_f3((i == IDX_ADDI) ? 0 : i - 9);
            d.fmt = FMT_I;
            if (i == IDX_SLLI || i == IDX_SRLI || i == IDX_SRAI) begin
                d.fmt = FMT_ISH;
                if (i == IDX_SRAI) d.f7 = 7'h20;
            end
        end else if (i <= IDX_LHU) begin
            d.op  = OP_LD;
            d.f3  = 3'((i - IDX_LB < 3) ? i - IDX_LB : i - IDX_LB + 1);
            d.fmt = FMT_LD;
        end else if (i <= IDX_SW) begin
            d.op  = OP_S;
            d.f3  = 3'(i - IDX_SB);
            d.fmt = FMT_S;
        end else if (i <= IDX_BGEU) begin
            d.op  = OP_B;
            d.f3  = 3'((i - IDX_BEQ < 2) ? i - IDX_BEQ : i - IDX_BEQ + 2);
            d.fmt = FMT_B;
        end else if (i == IDX_JAL) begin
            d.op  = OP_JAL;
            d.fmt = FMT_J;
        end else if (i == IDX_JALR) begin
            d.op  = OP_JALR;
            d.fmt = FMT_JALR;
        end else if (i == IDX_LUI) begin
            d.op  = OP_LUI;
            d.fmt = FMT_U;
        end else if (i == IDX_AUIPC) begin
            d.op  = OP_AUIPC;
            d.fmt = FMT_U;
        end else if (i == IDX_ENV) begin
            d.op  = OP_SYS;
            d.fmt = FMT_ENV;
        end else begin
            d.f3 = 3'(i - IDX_MUL);
            d.f7 = 7'h01;
        end
        return d;
    endfunction

endpackage

// File: rtl/ienc32_fmt.sv
// Combinational field assembly of one RV32IM word from decoded S1 contents.
// IENC32_RANGE_CHECK_EN adds immediate range/alignment flagging to err_o.
module ienc32_fmt
    import ienc32_pkg::*;
(
    input  req_t        req_i,
    input  dec_t        dec_i,
    input  logic        ill_i,
    output logic [31:0] inst_o,
    output logic        err_o
);

    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  op, f7;
    logic [2:0]  f3;

    assign imm = req_i.imm;
    assign rd  = req_i.rd;
    assign rs1 = req_i.rs1;
    assign rs2 = req_i.rs2;
    assign op  = dec_i.op;
    assign f3  = dec_i.f3;
    assign f7  = dec_i.f7;

    always_comb begin
        inst_o = '0;
        case (dec_i.fmt)
            FMT_R:                   inst_o = {f7, rs2, rs1, f3, rd, op};
            FMT_I, FMT_LD, FMT_JALR: inst_o = {imm[11:0], rs1, f3, rd, op};
            FMT_ISH:                 inst_o = {f7, imm[4:0], rs1, f3, rd, op};
            FMT_S:                   inst_o = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   inst_o = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_J:   inst_o = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            FMT_U:   inst_o = {imm[31:12], rd, op};
            FMT_ENV: inst_o = {11'd0, imm[0], 13'd0, op};
            default: inst_o = '0;
        endcase
        if (ill_i) inst_o = '0;
    end

`ifdef IENC32_RANGE_CHECK_EN
    logic fit12, fit13, fit21, rng_bad;
    assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        rng_bad = 1'b0;
        case (dec_i.fmt)
            FMT_I, FMT_LD, FMT_S, FMT_JALR: rng_bad = !fit12;
            FMT_B:   rng_bad = !fit13 | imm[0];
            FMT_J:   rng_bad = !fit21 | imm[0];
            FMT_ISH: rng_bad = |imm[31:5];
            FMT_U:   rng_bad = |imm[11:0];
            FMT_ENV: rng_bad = |imm[31:1];
            default: rng_bad = 1'b0;
        endcase
    end

    assign err_o = ill_i | rng_bad;
`else
    assign err_o = ill_i;
`endif

endmodule

// File: rtl/ienc32.sv
// Two-stage RV32IM encoder: S1 holds the request plus its decode, S2 the word.
// Optional immediate checking is enabled with IENC32_RANGE_CHECK_EN.
module ienc32
    import ienc32_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              addr_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic              s1_en, s2_en, s1_ill_q;
    req_t              s1_req_q;
    dec_t              s1_dec_q;
    logic [31:0]       inst_q, fmt_inst;
    logic              err_q, fmt_err;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Each stage advances when it is empty or the stage after it is moving.
    assign s2_en    = !s2_v_q || out_ready;
    assign s1_en    = !s1_v_q || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        s1_v_d = s1_en ? in_valid : s1_v_q;
        s2_v_d = s2_en ? s1_v_q : s2_v_q;
        cnt_d  = cnt_q;
        if (s2_v_q && out_ready) cnt_d = cnt_q + ADDR_W'(1);
        if (addr_clr)            cnt_d = '0;
    end

    ienc32_fmt u_fmt (
        .req_i  (s1_req_q),
        .dec_i  (s1_dec_q),
        .ill_i  (s1_ill_q),
        .inst_o (fmt_inst),
        .err_o  (fmt_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s1_ill_q <= 1'b0;
            s1_req_q <= '0;
            s1_dec_q <= '0;
            inst_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            cnt_q  <= cnt_d;
            if (s1_en && in_valid) begin
                s1_req_q <= '{rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
                s1_dec_q <= idx_lookup(in_idx);
                s1_ill_q <= (in_idx >= NR_INST_IDX);
            end
            if (s2_en && s1_v_q) begin
                inst_q <= fmt_inst;
                err_q  <= fmt_err;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out_inst  = inst_q;
    assign out_err   = err_q;
    assign out_addr  = cnt_q;

endmodule

// File: tb/tb_ienc32.sv
// Directed bench for ienc32 with a 2-bit address counter and hand-computed words.
module tb_ienc32;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [5:0]    in_idx = '0;
    logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0]   in_imm = '0;
    logic          addr_clr = 1'b0;
    logic          out_valid, out_ready = 1'b0, out_err;
    logic [31:0]   out_inst;
    logic [AW-1:0] out_addr;

    int checks = 0, failures = 0, acc_cnt = 0;
    logic [31:0]   cap_inst[$];
    logic [AW-1:0] cap_addr[$];
    logic          cap_err[$];

    ienc32 #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .addr_clr(addr_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+2, so negedge sees the values the next edge will use.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) acc_cnt++;
        if (!rst && out_valid && out_ready) begin
            cap_inst.push_back(out_inst);
            cap_addr.push_back(out_addr);
            cap_err.push_back(out_err);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [5:0] idx, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        int n = 0;
        in_valid = 1'b1; in_idx = idx; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        if (n == 50) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_cap(input int n);
        int k = 0;
        while (cap_inst.size() < n && k < 100) begin k++; @(negedge clk); end
        if (cap_inst.size() < n) chk("wait_timeout", 32'(cap_inst.size()), 32'(n));
        @(posedge clk); #2;
    endtask

    task automatic clr_addr();
        @(posedge clk); #2; addr_clr = 1'b1;
        @(posedge clk); #2; addr_clr = 1'b0;
    endtask

    task automatic flush();
        cap_inst.delete(); cap_addr.delete(); cap_err.delete();
    endtask

    initial begin
        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        out_ready = 1'b1;

        // single add: latency and first address
        send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        chk("lat_s1", 32'(out_valid), 0);
        @(posedge clk); #2;
        chk("lat_s2", 32'(out_valid), 1);
        wait_cap(1);
        chk("add_inst", cap_inst[0], 32'h003100B3);
        chk("add_addr", 32'(cap_addr[0]), 0);

        // back-to-back stream
        clr_addr(); flush();
        send(6'd1, 5'd5, 5'd6, 5'd7, 32'd0);
        send(6'd10, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
        send(6'd27, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        send(6'd35, 5'd1, 5'd0, 5'd0, 32'h12345000);
        wait_cap(4);
        chk("b2b_sub", cap_inst[0], 32'h407302B3);
        chk("b2b_addi", cap_inst[1], 32'hFFF00093);
        chk("b2b_beq", cap_inst[2], 32'hFE208EE3);
        chk("b2b_lui", cap_inst[3], 32'h123450B7);
        for (int i = 0; i < 4; i++) chk($sformatf("b2b_addr%0d", i), 32'(cap_addr[i]), 32'(i));

        // ecall / ebreak
        flush();
        send(6'd37, 5'd3, 5'd4, 5'd0, 32'd0);
        send(6'd37, 5'd3, 5'd4, 5'd0, 32'd1);
        wait_cap(2);
        chk("ecall", cap_inst[0], 32'h00000073);
        chk("ebreak", cap_inst[1], 32'h00100073);

        // illegal index and oversized immediate
        flush();
        send(6'd50, 5'd1, 5'd2, 5'd3, 32'h7);
        send(6'd10, 5'd1, 5'd0, 5'd0, 32'd2048);
        wait_cap(2);
        chk("ill_inst", cap_inst[0], 32'h0);
        chk("ill_err", 32'(cap_err[0]), 1);
        chk("ill_addr", 32'(cap_addr[0]), 2);
        chk("big_inst", cap_inst[1], 32'h80000093);
`ifdef IENC32_RANGE_CHECK_EN
        chk("big_err", 32'(cap_err[1]), 1);
`else
        chk("big_err", 32'(cap_err[1]), 0);
`endif

        // address wrap with a 2-bit counter
        clr_addr(); flush();
        send(6'd38, 5'd1, 5'd2, 5'd3, 32'd0);
        send(6'd21, 5'd1, 5'd2, 5'd0, 32'd4);
        for (int i = 0; i < 3; i++) send(6'd10, 5'd0, 5'd0, 5'd0, 32'd0);
        wait_cap(5);
        chk("mul_inst", cap_inst[0], 32'h023100B3);
        chk("lw_inst", cap_inst[1], 32'h00412083);
        chk("nop_err", 32'(cap_err[2]), 0);
        for (int i = 0; i < 5; i++) chk($sformatf("wrap_addr%0d", i), 32'(cap_addr[i]), 32'(i % 4));

        // addr_clr coinciding with the handshake of the word at address 2
        clr_addr(); flush();
        send(6'd10, 5'd0, 5'd0, 5'd0, 32'd0);
        send(6'd10, 5'd0, 5'd0, 5'd0, 32'd0);
        wait_cap(2);
        out_ready = 1'b0;
        send(6'd11, 5'd1, 5'd2, 5'd0, 32'd5);
        send(6'd10, 5'd0, 5'd0, 5'd0, 32'd0);
        @(posedge clk); #2; addr_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #2; addr_clr = 1'b0;
        wait_cap(4);
        chk("clr_inst", cap_inst[2], 32'h00514093);
        chk("clr_addr_kept", 32'(cap_addr[2]), 2);
        chk("clr_addr_next", 32'(cap_addr[3]), 0);

        // backpressure: two buffered, then in_ready low, outputs frozen
        clr_addr(); flush();
        acc_cnt = 0;
        out_ready = 1'b0;
        fork
            begin
                send(6'd2, 5'd3, 5'd4, 5'd5, 32'd0);
                send(6'd26, 5'd0, 5'd2, 5'd3, 32'd8);
                send(6'd33, 5'd1, 5'd0, 5'd0, 32'd8);
                send(6'd16, 5'd1, 5'd2, 5'd0, 32'd3);
            end
            begin
                repeat (3) @(negedge clk);
                chk("bp_inst_a", out_inst, 32'h005241B3);
                repeat (2) @(negedge clk);
                chk("bp_in_ready", 32'(in_ready), 0);
                chk("bp_accepts", 32'(acc_cnt), 2);
                chk("bp_valid", 32'(out_valid), 1);
                chk("bp_inst_b", out_inst, 32'h005241B3);
                chk("bp_addr", 32'(out_addr), 0);
                @(posedge clk); #2; out_ready = 1'b1;
            end
        join
        wait_cap(4);
        chk("bp_w0", cap_inst[0], 32'h005241B3);
        chk("bp_w1", cap_inst[1], 32'h00312423);
        chk("bp_w2", cap_inst[2], 32'h008000EF);
        chk("bp_w3", cap_inst[3], 32'h40315093);
        for (int i = 0; i < 4; i++) chk($sformatf("bp_addr%0d", i), 32'(cap_addr[i]), 32'(i));

        // asynchronous reset with words in flight
        flush();
        send(6'd10, 5'd0, 5'd0, 5'd0, 32'd0);
        wait_cap(1);
        out_ready = 1'b0;
        send(6'd50, 5'd0, 5'd0, 5'd0, 32'd0);
        send(6'd10, 5'd0, 5'd0, 5'd0, 32'd0);
        @(negedge clk);
        chk("pre_rst_err", 32'(out_err), 1);
        chk("pre_rst_addr", 32'(out_addr), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_inst", out_inst, 0);
        chk("arst_err", 32'(out_err), 0);
        chk("arst_addr", 32'(out_addr), 0);
        chk("arst_in_ready", 32'(in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
